// File: rtl/div16_pkg.sv
// div16_pkg: shared types and sizing for the sequential restoring divider.
// Holds the FSM state encoding, default operand widths and the iteration
// counter width helper.
package div16_pkg;

    localparam int DVD_W_DEF = 32;
    localparam int DVS_W_DEF = 16;

    // Counter must be able to hold the value DVD_W (step count).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DVD_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div16_step.sv
// div16_step: one combinational restoring-division iteration.
// Shifts the quotient MSB into the partial remainder, then subtracts the
// divisor when it fits and records the outcome in the quotient LSB.
module div16_step #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 16
) (
    input  logic [DVS_W:0]   r,
    input  logic [DVD_W-1:0] q,
    input  logic [DVS_W-1:0] d,
    output logic [DVS_W:0]   r_nxt,
    output logic [DVD_W-1:0] q_nxt
);

    localparam int RW = DVS_W + 1;

    logic [DVS_W:0] r_sh;

    // The partial remainder stays below 2*divisor, so the top bit of r is
    // always shifted out as zero and the cast drops nothing meaningful.
    assign r_sh = RW'({r, q[DVD_W-1]});

    // Restore-or-subtract decision for this bit.
    always_comb begin
        r_nxt = r_sh;
        q_nxt = {q[DVD_W-2:0], 1'b0};
        if (r_sh >= {1'b0, d}) begin
            r_nxt = r_sh - {1'b0, d};
            q_nxt = {q[DVD_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div16.sv
// seq_div16: multi-cycle unsigned restoring divider, one quotient bit per clock.
// IDLE -> RUN (DVD_W steps) -> DONE -> IDLE. Quotient and remainder are read
// straight from the working registers, which are left untouched in DONE/IDLE.
// Optional feature: define DIV16_ZERO_DETECT_EN to add the div_zero flag and a
// one-edge shortcut to DONE when the divisor is zero.
module seq_div16
    import div16_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
`ifdef DIV16_ZERO_DETECT_EN
    output logic             div_zero,
`endif
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
);

    localparam int CNT_BITS = cnt_width(DVD_W);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DVD_W - 1);

    state_e              state;
    logic [DVD_W-1:0]    q_q;
    logic [DVS_W:0]      r_q;
    logic [DVS_W-1:0]    dvs_q;
    logic [CNT_BITS-1:0] cnt;
    logic [DVD_W-1:0]    q_nxt;
    logic [DVS_W:0]      r_nxt;

    div16_step #(
        .DVD_W (DVD_W),
        .DVS_W (DVS_W)
    ) u_step (
        .r     (r_q),
        .q     (q_nxt_src()),
        .d     (dvs_q),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    function automatic logic [DVD_W-1:0] q_nxt_src();
        return q_q;
    endfunction

    // FSM plus datapath registers; operands are captured only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q_q      <= '0;
            r_q      <= '0;
            dvs_q    <= '0;
            cnt      <= '0;
`ifdef DIV16_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_q   <= dividend;
                        dvs_q <= divisor;
                        r_q   <= '0;
                        cnt   <= '0;
                        state <= RUN;
`ifdef DIV16_ZERO_DETECT_EN
                        div_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Same values the full sequence would reach, without the wait.
                            q_q      <= '1;
                            r_q      <= {1'b0, dividend[DVS_W-1:0]};
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    q_q <= q_nxt;
                    r_q <= r_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign quotient  = q_q;
    assign remainder = r_q[DVS_W-1:0];

endmodule
